// File: rtl/irq_stim_dev_pkg.sv
// Shared definitions for the interrupt stimulus peripheral: register offsets,
// mode and state encodings, and the default window base.
package irq_stim_pkg;

    localparam logic [31:0] ADDR_BASE_DEFAULT = 32'h0000_7F20;

    localparam logic [3:0] OFF_ACK   = 4'h0;
    localparam logic [3:0] OFF_CTRL  = 4'h4;
    localparam logic [3:0] OFF_LOAD  = 4'h8;
    localparam logic [3:0] OFF_COUNT = 4'hC;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'd0,
        MODE_ONESHOT  = 2'd1,
        MODE_PERIODIC = 2'd2,
        MODE_PCMATCH  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        PENDING = 2'd2
    } state_e;

endpackage

// File: rtl/irq_stim_dev_if.sv
// CPU data-bus slice seen by the interrupt stimulus peripheral.
interface irq_stim_dev_if;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] dev_rdata;
    logic        dev_hit;

    modport master (
        output m_data_addr,
        output m_data_wdata,
        output m_data_byteen,
        input  dev_rdata,
        input  dev_hit
    );

    modport slave (
        input  m_data_addr,
        input  m_data_wdata,
        input  m_data_byteen,
        output dev_rdata,
        output dev_hit
    );
endinterface

// File: rtl/irq_stim_dev_down_counter.sv
// Loadable down counter that saturates at zero; expire flags the edge on
// which a running count steps from 1 to 0.
module irq_down_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             run,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (run && (count_reg != '0)) begin
            count_reg <= count_reg - CNT_W'(1);
        end
    end

    assign count  = count_reg;
    // Independent of load so the parent can reload on the same edge it sees expire.
    assign expire = run && (count_reg == CNT_W'(1));

endmodule

// File: rtl/irq_stim_dev.sv
// Memory-mapped interrupt source: fires after a delay, periodically, or on a
// PC match, and holds the interrupt line until the CPU stores to ACK.
module irq_stim_dev
    import irq_stim_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = ADDR_BASE_DEFAULT,
    parameter int          CNT_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    irq_stim_dev_if.slave      bus,
    input  logic [31:0]        macroscopic_pc,
    output logic               interrupt
);

    state_e           state_reg;
    mode_e            mode_reg;
    logic             enable_reg;
    logic [CNT_W-1:0] load_reg;
    logic             interrupt_reg;
    logic             overrun_reg;

    logic [CNT_W-1:0] count;
    logic             cnt_expire;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_run;

    logic [3:0]  reg_off;
    logic        hit;
    logic        wr_en;
    logic        wr_ack;
    logic        wr_ctrl;
    logic        wr_load;
    logic [31:0] reg_val;
    logic [31:0] merged;
    logic [31:0] load_ext;
    logic [31:0] count_ext;
    logic [CNT_W-1:0] reload_val;
    logic        ctrl_en_next;
    mode_e       ctrl_mode_next;
    logic        ctrl_arms;
    logic        count_mode;
    logic        pc_match;
    logic        fire;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^bus.m_data_addr[1:0];

    assign reg_off = {bus.m_data_addr[3:2], 2'b00};
    assign hit     = (bus.m_data_addr[31:4] == ADDR_BASE[31:4]);
    assign wr_en   = hit && (bus.m_data_byteen != 4'b0000);
    assign wr_ack  = wr_en && (reg_off == OFF_ACK);
    assign wr_ctrl = wr_en && (reg_off == OFF_CTRL);
    assign wr_load = wr_en && (reg_off == OFF_LOAD);

    assign load_ext  = 32'(load_reg);
    assign count_ext = 32'(count);

    always_comb begin
        reg_val = '0;
        case (reg_off)
            OFF_ACK:   reg_val = {30'b0, overrun_reg, interrupt_reg};
            OFF_CTRL:  reg_val = {29'b0, mode_reg, enable_reg};
            OFF_LOAD:  reg_val = load_ext;
            OFF_COUNT: reg_val = count_ext;
            default:   reg_val = '0;
        endcase
    end

    assign bus.dev_rdata = hit ? reg_val : 32'h0;
    assign bus.dev_hit   = hit;

    // Unselected byte lanes keep the addressed register's current contents.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            assign merged[gi*8 +: 8] = bus.m_data_byteen[gi] ? bus.m_data_wdata[gi*8 +: 8]
                                                             : reg_val[gi*8 +: 8];
        end
    endgenerate

    assign ctrl_en_next   = merged[0];
    assign ctrl_mode_next = mode_e'(merged[2:1]);
    assign ctrl_arms      = ctrl_en_next && (ctrl_mode_next != MODE_OFF);

    assign reload_val = (load_reg == '0) ? CNT_W'(1) : load_reg;
    assign count_mode = (mode_reg == MODE_ONESHOT) || (mode_reg == MODE_PERIODIC);
    assign pc_match   = ((macroscopic_pc & ~32'h3) == (load_ext & ~32'h3));

    // A CTRL write restarts the machine, so it suppresses any fire on that edge.
    assign fire = (state_reg == ARMED) && !wr_ctrl &&
                  ((count_mode && cnt_expire) || ((mode_reg == MODE_PCMATCH) && pc_match));

    assign cnt_run      = (state_reg == ARMED) && count_mode && !wr_ctrl;
    assign cnt_load     = (wr_ctrl && ctrl_arms) || (fire && (mode_reg == MODE_PERIODIC));
    assign cnt_load_val = (wr_ctrl && (ctrl_mode_next == MODE_PCMATCH)) ? '0 : reload_val;

    irq_down_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .run      (cnt_run),
        .count    (count),
        .expire   (cnt_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            mode_reg      <= MODE_OFF;
            enable_reg    <= 1'b0;
            load_reg      <= '0;
            interrupt_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (wr_load) begin
                load_reg <= CNT_W'(merged);
            end

            if (wr_ctrl) begin
                enable_reg <= ctrl_en_next;
                mode_reg   <= ctrl_mode_next;
                state_reg  <= ctrl_arms ? ARMED : IDLE;
            end else if (fire && (mode_reg != MODE_PERIODIC)) begin
                enable_reg <= 1'b0;
                state_reg  <= PENDING;
            end else if (wr_ack && (state_reg == PENDING)) begin
                state_reg <= IDLE;
            end

            // Fire beats a same-edge ACK for the line itself.
            if (fire) begin
                interrupt_reg <= 1'b1;
            end else if (wr_ack) begin
                interrupt_reg <= 1'b0;
            end

            if (wr_ack) begin
                overrun_reg <= 1'b0;
            end else if (fire && (mode_reg == MODE_PERIODIC) && interrupt_reg) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    assign interrupt = interrupt_reg;

endmodule

// File: tb/tb_irq_stim_dev.sv
// Directed bench for irq_stim_dev: a register-access vector table followed by
// timed sequences for oneshot, periodic, PC match and asynchronous reset.
module tb_irq_stim_dev;

    localparam logic [31:0] A_ACK   = 32'h0000_7F20;
    localparam logic [31:0] A_CTRL  = 32'h0000_7F24;
    localparam logic [31:0] A_LOAD  = 32'h0000_7F28;
    localparam logic [31:0] A_COUNT = 32'h0000_7F2C;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc;
    logic        interrupt;

    int n_cmp = 0;
    int n_err = 0;

    irq_stim_dev_if bus_if ();

    irq_stim_dev dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus_if),
        .macroscopic_pc (pc),
        .interrupt      (interrupt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] raddr;
        logic [31:0] exp_rdata;
        logic        exp_hit;
    } vec_t;

    vec_t vecs [11];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_irq(input string name, input logic exp);
        check32(name, {31'b0, interrupt}, {31'b0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus_if.m_data_addr   = a;
        bus_if.m_data_wdata  = d;
        bus_if.m_data_byteen = be;
        @(posedge clk);
        #1;
        $display("[%0t] write addr=0x%08h data=0x%08h be=%b", $time, a, d, be);
        bus_if.m_data_byteen = 4'h0;
        bus_if.m_data_addr   = 32'h0;
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus_if.m_data_addr = a;
        #1;
        $display("[%0t] read  addr=0x%08h data=0x%08h", $time, a, bus_if.dev_rdata);
        check32(name, bus_if.dev_rdata, exp);
        bus_if.m_data_addr = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.m_data_addr   = 32'h0;
        bus_if.m_data_wdata  = 32'h0;
        bus_if.m_data_byteen = 4'h0;
        pc = 32'h0000_3000;

        vecs[0]  = '{A_LOAD,        32'h1122_3344, 4'hF, A_LOAD,        32'h1122_3344, 1'b1};
        vecs[1]  = '{A_LOAD,        32'hAABB_CCDD, 4'h2, A_LOAD,        32'h1122_CC44, 1'b1};
        vecs[2]  = '{A_LOAD,        32'hAABB_CCDD, 4'h9, A_LOAD,        32'hAA22_CCDD, 1'b1};
        vecs[3]  = '{32'h0000_7F30, 32'hFFFF_FFFF, 4'hF, 32'h0000_7F30, 32'h0,         1'b0};
        vecs[4]  = '{A_LOAD,        32'h0000_DEAD, 4'h0, A_LOAD,        32'hAA22_CCDD, 1'b1};
        vecs[5]  = '{32'h0000_7F2B, 32'h0000_0003, 4'hF, A_LOAD,        32'h0000_0003, 1'b1};
        vecs[6]  = '{A_COUNT,       32'h1234_5678, 4'hF, A_COUNT,       32'h0,         1'b1};
        vecs[7]  = '{A_CTRL,        32'hFFFF_FFFC, 4'hF, A_CTRL,        32'h0000_0004, 1'b1};
        vecs[8]  = '{32'h0000_7F10, 32'hFFFF_FFFF, 4'hF, 32'h0000_7F1C, 32'h0,         1'b0};
        vecs[9]  = '{A_CTRL,        32'h0000_0000, 4'hF, A_LOAD,        32'h0000_0003, 1'b1};
        vecs[10] = '{A_ACK,         32'hFFFF_FFFF, 4'hF, A_ACK,         32'h0,         1'b1};

        // Reset state, observed while reset is held
        #3;
        check_irq("rst_irq", 1'b0);
        rd_check("rst_status", A_ACK, 32'h0);
        rd_check("rst_ctrl", A_CTRL, 32'h0);
        rd_check("rst_count", A_COUNT, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Register access table
        for (int i = 0; i < 11; i++) begin
            bus_write(vecs[i].waddr, vecs[i].wdata, vecs[i].be);
            bus_if.m_data_addr = vecs[i].raddr;
            #1;
            $display("[%0t] read  addr=0x%08h data=0x%08h hit=%b", $time, vecs[i].raddr,
                     bus_if.dev_rdata, bus_if.dev_hit);
            check32($sformatf("vec%0d_rdata", i), bus_if.dev_rdata, vecs[i].exp_rdata);
            check32($sformatf("vec%0d_hit", i), {31'b0, bus_if.dev_hit}, {31'b0, vecs[i].exp_hit});
            bus_if.m_data_addr = 32'h0;
        end

        // ONESHOT, LOAD=3: interrupt appears after the third edge past arming
        bus_write(A_LOAD, 32'd3, 4'hF);
        bus_write(A_CTRL, 32'h3, 4'hF);
        check_irq("os_e0_irq", 1'b0);
        rd_check("os_e0_count", A_COUNT, 32'd3);
        tick();
        check_irq("os_e1_irq", 1'b0);
        rd_check("os_e1_count", A_COUNT, 32'd2);
        tick();
        check_irq("os_e2_irq", 1'b0);
        tick();
        check_irq("os_e3_irq", 1'b1);
        rd_check("os_status", A_ACK, 32'h1);
        rd_check("os_ctrl", A_CTRL, 32'h2);
        rd_check("os_count", A_COUNT, 32'h0);
        tick();
        check_irq("os_hold_irq", 1'b1);
        bus_write(A_ACK, 32'h0, 4'hF);
        check_irq("os_ack_irq", 1'b0);
        rd_check("os_ack_status", A_ACK, 32'h0);

        // PERIODIC, LOAD=4: fires every 4 edges, overrun on unacknowledged repeat
        bus_write(A_LOAD, 32'd4, 4'hF);
        bus_write(A_CTRL, 32'h5, 4'hF);
        repeat (3) tick();
        check_irq("per_e3_irq", 1'b0);
        tick();
        check_irq("per_e4_irq", 1'b1);
        rd_check("per_e4_status", A_ACK, 32'h1);
        repeat (3) tick();
        rd_check("per_e7_status", A_ACK, 32'h1);
        tick();
        rd_check("per_e8_status", A_ACK, 32'h3);
        bus_write(A_ACK, 32'h0, 4'h1);
        rd_check("per_e9_status", A_ACK, 32'h0);
        tick();
        tick();
        check_irq("per_e11_irq", 1'b0);
        tick();
        check_irq("per_e12_irq", 1'b1);
        rd_check("per_e12_status", A_ACK, 32'h1);
        repeat (3) tick();
        // ACK lands on the expiry edge: line stays up, no overrun
        bus_write(A_ACK, 32'h0, 4'hF);
        rd_check("per_same_edge_status", A_ACK, 32'h1);
        rd_check("per_reload_count", A_COUNT, 32'd4);
        bus_write(A_CTRL, 32'h0, 4'hF);
        check_irq("per_disable_irq", 1'b1);
        rd_check("per_disable_count", A_COUNT, 32'd4);
        tick();
        rd_check("per_frozen_count", A_COUNT, 32'd4);
        bus_write(A_ACK, 32'h0, 4'hF);
        check_irq("per_final_ack_irq", 1'b0);

        // PCMATCH on 0x3010
        bus_write(A_LOAD, 32'h0000_3010, 4'hF);
        pc = 32'h0000_3008;
        bus_write(A_CTRL, 32'h7, 4'hF);
        check_irq("pc_3008_irq", 1'b0);
        pc = 32'h0000_300C;
        tick();
        check_irq("pc_300c_irq", 1'b0);
        pc = 32'h0000_3010;
        tick();
        check_irq("pc_3010_irq", 1'b1);
        rd_check("pc_ctrl", A_CTRL, 32'h6);
        rd_check("pc_count", A_COUNT, 32'h0);
        bus_write(A_ACK, 32'h0, 4'hF);
        check_irq("pc_ack_irq", 1'b0);
        pc = 32'h0000_3000;
        tick();
        pc = 32'h0000_3010;
        tick();
        check_irq("pc_no_rearm_irq", 1'b0);
        pc = 32'h0000_3000;
        bus_write(A_CTRL, 32'h7, 4'hF);
        pc = 32'h0000_3013;
        tick();
        check_irq("pc_masked_irq", 1'b1);
        bus_write(A_ACK, 32'h0, 4'hF);

        // Asynchronous reset with COUNT=5 and interrupt pending
        bus_write(A_LOAD, 32'd5, 4'hF);
        bus_write(A_CTRL, 32'h5, 4'hF);
        repeat (5) tick();
        check_irq("ar_pre_irq", 1'b1);
        rd_check("ar_pre_count", A_COUNT, 32'd5);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_irq("ar_irq", 1'b0);
        rd_check("ar_count", A_COUNT, 32'h0);
        rd_check("ar_ctrl", A_CTRL, 32'h0);
        @(posedge clk);
        #1;
        rd_check("ar_status", A_ACK, 32'h0);
        rd_check("ar_load", A_LOAD, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        check_irq("ar_post_irq", 1'b0);
        rd_check("ar_post_count", A_COUNT, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irq_stim_dev.md
Name: irq_stim_dev

Overview:
- Memory-mapped interrupt-source peripheral on the CPU data bus, window based at 0x7F20.
- Raises the CPU `interrupt` line after a programmed delay, periodically, or when the macroscopic PC hits a programmed address.
- Holds the line until the CPU stores to the ACK register, completing the request/acknowledge handshake from the device side.

Parameters:
- ADDR_BASE, 32'h0000_7F20, word-aligned base of the 4-word register window.
- CNT_W, 32, counter/LOAD width; LOAD and COUNT are zero-extended to 32 bits on read.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; reset==0 forces the reset state immediately.
- m_data_addr  in  32  CPU data address; bits [1:0] ignored.
- m_data_wdata  in  32  CPU store data.
- m_data_byteen  in  4  store byte enables; 4'b0000 means no write.
- dev_rdata  out  32  combinational read data for the addressed register; 0 outside the window.
- dev_hit  out  1  combinational: m_data_addr[31:4] == ADDR_BASE[31:4].
- macroscopic_pc  in  32  CPU architectural PC; compared with bits [1:0] masked.
- interrupt  out  1  registered interrupt request to the CPU.

Behaviour:
- Register map, word offsets from ADDR_BASE:
  - +0x0 ACK/STATUS. Read: {30'b0, overrun, interrupt}. Any write with nonzero byteen clears interrupt and overrun.
  - +0x4 CTRL. Bit [0] enable; bits [2:1] mode (0 OFF, 1 ONESHOT, 2 PERIODIC, 3 PCMATCH); other bits read 0.
  - +0x8 LOAD. Delay/period in cycles, or the PC match address.
  - +0xC COUNT. Read-only current counter; writes ignored.
- Writes are byte-merged per m_data_byteen and take effect at the rising edge where byteen != 0 and dev_hit == 1.
- Reset values: interrupt=0, overrun=0, CTRL=0, LOAD=0, COUNT=0, state IDLE.
- State machine:
  - IDLE: entered when enable=0 or mode=OFF.
  - ARMED: counting, or PC-watching in PCMATCH.
  - PENDING: interrupt=1, waiting for ACK.
- Arming: a CTRL write leaving enable=1 and mode != OFF loads COUNT <= max(LOAD,1) at that edge and enters ARMED. A CTRL write restarts from any state but does not clear a pending interrupt.
- ONESHOT:
  - COUNT decrements by 1 per edge while ARMED.
  - At the edge where COUNT goes 1 to 0: interrupt <= 1, CTRL.enable <= 0, go to PENDING.
  - Latency: LOAD=N gives interrupt high N cycles after the arming edge. LOAD=0 behaves as LOAD=1.
- PERIODIC:
  - At expiry, interrupt <= 1 and COUNT <= max(LOAD,1) in the same edge; counting continues with no gap.
  - If interrupt is already 1 at expiry, set overrun <= 1; interrupt stays 1.
- PCMATCH:
  - While ARMED, when (macroscopic_pc & ~3) == (LOAD & ~3) at an edge: interrupt <= 1, enable <= 0, go to PENDING.
  - Single-shot; COUNT holds 0.
- ACK write to +0x0:
  - Clears interrupt at that edge and returns to IDLE if enable=0, else stays ARMED (PERIODIC).
  - Same-edge ACK and expiry/match: the fire wins, interrupt stays 1, and overrun is not set.
- LOAD written while ARMED: takes effect at the next reload/arm only; the current COUNT is unaffected.
- Disabling mid-count (CTRL write with enable=0): COUNT freezes, state goes to IDLE, a pending interrupt is kept.
- Reset asserted mid-operation: all state returns to reset values asynchronously; interrupt drops the same instant.
- Addresses outside the window: no write effect; dev_rdata=0.
- Counter wrap is impossible: COUNT never decrements below 0.

Decomposition:
- Shared package (irq_stim_pkg):
  - Register offsets: ACK=0x0, CTRL=0x4, LOAD=0x8, COUNT=0xC.
  - Mode encodings: MODE_OFF, MODE_ONESHOT, MODE_PERIODIC, MODE_PCMATCH.
  - State enum: IDLE, ARMED, PENDING.
  - Default ADDR_BASE.
- Sub-module irq_down_counter:
  - Inputs: load, load_val, run.
  - Outputs: count, expire.
  - expire pulses on the 1-to-0 step.
- The top block holds the register file, byte-merge logic, FSM and PC compare.

Test Plan:
- Reset with reset=0 mid-count (COUNT=5, interrupt=1) -> interrupt, COUNT and CTRL read 0 immediately, before the next clock edge.
- ONESHOT: write LOAD=3, then CTRL=0x3 -> interrupt rises exactly 3 cycles after the CTRL edge; STATUS reads 0x1; CTRL.enable reads 0. Store to 0x7F20 -> interrupt 0 the next cycle.
- PERIODIC with LOAD=4 and no ACK -> interrupt high at cycle 4; at cycle 8 overrun=1 and STATUS reads 0x3. ACK -> STATUS 0x0; interrupt re-rises at cycle 12.
- PCMATCH with LOAD=0x3010 and PC sequence 0x3008, 0x300C, 0x3010 -> interrupt rises on the 0x3010 edge only. A second pass through 0x3010 with no re-arm leaves interrupt low.
- ACK on the same edge as a PERIODIC expiry -> interrupt stays 1 and overrun stays 0.
- Byte-enable writes:
  - LOAD=0x11223344, then store 0xAABBCCDD with byteen=4'b0010 -> LOAD reads 0x1122CC44.
  - Store to 0x7F30 (outside the window) -> no register change; dev_hit=0.
